// File: rtl/button_debounce_pkg.sv
// rtl/button_debounce_pkg.sv - shared FSM state encodings and 100 MHz timing defaults for button_debounce
package button_debounce_pkg;

   // Debounce FSM state encodings
   localparam logic [1:0] STABLE_LO = 2'd0;
   localparam logic [1:0] CHK_HI    = 2'd1;
   localparam logic [1:0] STABLE_HI = 2'd2;
   localparam logic [1:0] CHK_LO    = 2'd3;

   // Defaults for a 100 MHz clock: 10 ms debounce window, 1 s long-press
   localparam int DEF_N_CH        = 4;
   localparam int DEF_DB_CYCLES   = 1_000_000;
   localparam int DEF_HOLD_CYCLES = 100_000_000;

endpackage

// File: rtl/button_debounce_channel.sv
// rtl/button_debounce_channel.sv - one button: 2-flop synchroniser, qualified-stable debounce FSM, optional hold timer (BUTTON_HOLD_EN)
module button_debounce_channel
   import button_debounce_pkg::*;
#(
   parameter int DB_CYCLES = DEF_DB_CYCLES
`ifdef BUTTON_HOLD_EN
   ,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_hold
);

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DB_CYCLES);

   logic          s1;
   logic          s2;
   logic [1:0]    state;
   logic [CW-1:0] cnt;

   // Bring the asynchronous pin into the clock domain; only s2 is used downstream
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= btn_in;
         s2 <= s1;
      end
   end

   // Accept a level change only after DB_CYCLES further matching samples; any opposite sample drops back
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= STABLE_LO;
         cnt         <= '0;
         btn_level   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
      end else begin
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
         case (state)
            STABLE_LO: begin
               if (s2) begin
                  state <= CHK_HI;
                  cnt   <= '0;
               end
            end
            CHK_HI: begin
               if (!s2) begin
                  state <= STABLE_LO;
               end else if (cnt == CNT_LAST) begin
                  state     <= STABLE_HI;
                  btn_level <= 1'b1;
                  btn_press <= 1'b1;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            STABLE_HI: begin
               if (!s2) begin
                  state <= CHK_LO;
                  cnt   <= '0;
               end
            end
            CHK_LO: begin
               if (s2) begin
                  state <= STABLE_HI;
               end else if (cnt == CNT_LAST) begin
                  state       <= STABLE_LO;
                  btn_level   <= 1'b0;
                  btn_release <= 1'b1;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= STABLE_LO;
            end
         endcase
      end
   end

`ifdef BUTTON_HOLD_EN
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

   logic [HW-1:0] hold_cnt;
   logic          accept_hi;

   assign accept_hi = (state == CHK_HI) && s2 && (cnt == CNT_LAST);

   // Long-press timer: restarts only on an accepted press, keeps running through release bounce, fires once then saturates
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt <= '0;
         btn_hold <= 1'b0;
      end else begin
         btn_hold <= 1'b0;
         if (accept_hi) begin
            hold_cnt <= '0;
         end else if ((state == STABLE_HI) || (state == CHK_LO)) begin
            if (hold_cnt == HOLD_LAST) begin
               btn_hold <= 1'b1;
            end
            if (hold_cnt != HOLD_MAX) begin
               hold_cnt <= hold_cnt + 1'b1;
            end
         end
      end
   end
`else
   assign btn_hold = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - N_CH independent push-button conditioners; long-press strobe only when BUTTON_HOLD_EN is defined
module button_debounce
   import button_debounce_pkg::*;
#(
   parameter int N_CH        = DEF_N_CH,
   parameter int DB_CYCLES   = DEF_DB_CYCLES,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] btn_press,
   output logic [N_CH-1:0] btn_release,
   output logic [N_CH-1:0] btn_hold
);

   // Both windows must be at least one cycle; an illegal override yields an inert block instead of underflowed counts
   localparam bit CFG_OK = (DB_CYCLES >= 1) && (HOLD_CYCLES >= 1);

   if (CFG_OK) begin : g_cfg_ok
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         button_debounce_channel #(
            .DB_CYCLES(DB_CYCLES)
`ifdef BUTTON_HOLD_EN
            ,
            .HOLD_CYCLES(HOLD_CYCLES)
`endif
         ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .btn_in     (btn_in[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i]),
            .btn_hold   (btn_hold[i])
         );
      end
   end else begin : g_cfg_bad
      assign btn_level   = {N_CH{1'b0}};
      assign btn_press   = {N_CH{1'b0}};
      assign btn_release = {N_CH{1'b0}};
      assign btn_hold    = {N_CH{1'b0}};
   end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - self-checking bench for button_debounce (DB_CYCLES=8, HOLD_CYCLES=32)
module tb_button_debounce;

   localparam int N_CH = 4;
   localparam int DB   = 8;
   localparam int HOLD = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N_CH-1:0] btn_in = '0;
   logic [N_CH-1:0] btn_level;
   logic [N_CH-1:0] btn_press;
   logic [N_CH-1:0] btn_release;
   logic [N_CH-1:0] btn_hold;

   always #5 clk = ~clk;

   button_debounce #(
      .N_CH       (N_CH),
      .DB_CYCLES  (DB),
      .HOLD_CYCLES(HOLD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_in     (btn_in),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release),
      .btn_hold   (btn_hold)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference model: a change is accepted once the last DB+1 synchronised samples
   // all differ from the current level; samples reach the FSM two edges after the pin.
   bit              pin_hist [N_CH][$];
   bit              seen     [N_CH][$];
   bit              m_level  [N_CH];
   int              m_press_edge [N_CH];
   int              edge_no = 0;
   logic [N_CH-1:0] m_lvl, m_prs, m_rel, m_hld;

   task automatic model_edge();
      edge_no++;
      for (int c = 0; c < N_CH; c++) begin
         bit s2;
         bit all_diff;
         m_prs[c] = 1'b0;
         m_rel[c] = 1'b0;
         m_hld[c] = 1'b0;
         if (rst) begin
            pin_hist[c].delete();
            pin_hist[c].push_back(1'b0);
            pin_hist[c].push_back(1'b0);
            seen[c].delete();
            m_level[c] = 1'b0;
            m_press_edge[c] = -1;
         end else begin
            s2 = pin_hist[c][pin_hist[c].size() - 2];
            pin_hist[c].push_back(btn_in[c]);
            if (pin_hist[c].size() > 4) void'(pin_hist[c].pop_front());
            seen[c].push_back(s2);
            if (seen[c].size() > DB + 1) void'(seen[c].pop_front());
            if (m_level[c] && m_press_edge[c] >= 0 && (edge_no - m_press_edge[c]) == HOLD)
               m_hld[c] = 1'b1;
            all_diff = (seen[c].size() == DB + 1);
            for (int i = 0; i < seen[c].size(); i++)
               if (seen[c][i] == m_level[c]) all_diff = 1'b0;
            if (all_diff) begin
               m_level[c] = !m_level[c];
               if (m_level[c]) begin
                  m_prs[c] = 1'b1;
                  m_press_edge[c] = edge_no;
               end else begin
                  m_rel[c] = 1'b1;
               end
            end
         end
         m_lvl[c] = m_level[c];
      end
`ifndef BUTTON_HOLD_EN
      m_hld = '0;
`endif
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, compare 1 time unit later
   task automatic step(input logic [N_CH-1:0] b, input logic r);
      btn_in = b;
      rst    = r;
      @(posedge clk);
      model_edge();
      #1;
      check("model", {16'h0, btn_level, btn_press, btn_release, btn_hold},
            {16'h0, m_lvl, m_prs, m_rel, m_hld});
   endtask

   task automatic obs(input int ch, input int idx, inout int npress, inout int press_at, inout int nrel);
      if (btn_press[ch]) begin
         npress++;
         press_at = idx;
      end
      if (btn_release[ch]) nrel++;
   endtask

   // reps x (high hi_len, low lo_len) then hold high: exactly one press, DB+2 edges after the final rise
   task automatic burst_then_hold(input string name, input int ch, input int hi_len, input int lo_len, input int reps);
      int idx = 0, rise = 0, npress = 0, press_at = -1, nrel = 0;
      logic [N_CH-1:0] m;
      m = '0;
      m[ch] = 1'b1;
      for (int r = 0; r < reps; r++) begin
         for (int i = 0; i < hi_len; i++) begin step(m, 1'b0); obs(ch, idx, npress, press_at, nrel); idx++; end
         for (int i = 0; i < lo_len; i++) begin step('0, 1'b0); obs(ch, idx, npress, press_at, nrel); idx++; end
      end
      rise = idx;
      for (int i = 0; i < 25; i++) begin step(m, 1'b0); obs(ch, idx, npress, press_at, nrel); idx++; end
      check({name, "_npress"}, npress, 1);
      check({name, "_latency"}, press_at - rise, DB + 2);
      check({name, "_nrelease"}, nrel, 0);
      for (int i = 0; i < DB + 6; i++) step('0, 1'b0);
   endtask

   typedef struct {
      logic [N_CH-1:0] btn;
      int              n;
      logic [N_CH-1:0] lvl;
      logic [N_CH-1:0] prs;
      logic [N_CH-1:0] rel;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [N_CH-1:0] b, input int n, input logic [N_CH-1:0] l,
                      input logic [N_CH-1:0] p, input logic [N_CH-1:0] r);
      vec_t v;
      v.btn = b; v.n = n; v.lvl = l; v.prs = p; v.rel = r;
      tbl.push_back(v);
   endtask

   initial begin
      int press_at, p, nh, hat;

      // Directed vectors: apply btn for n edges, then compare level/press/release
      add(4'h1, 10, 4'h0, 4'h0, 4'h0);   // clean press, still qualifying
      add(4'h1,  1, 4'h1, 4'h1, 4'h0);   // press at k+10
      add(4'h1,  1, 4'h1, 4'h0, 4'h0);   // strobe is one cycle
      add(4'h1,  5, 4'h1, 4'h0, 4'h0);
      add(4'h0, 10, 4'h1, 4'h0, 4'h0);   // release qualifying
      add(4'h0,  1, 4'h0, 4'h0, 4'h1);   // release at first low + 10
      add(4'h0,  1, 4'h0, 4'h0, 4'h0);
      add(4'h1, 10, 4'h0, 4'h0, 4'h0);
      add(4'h1,  1, 4'h1, 4'h1, 4'h0);
      add(4'h1,  3, 4'h1, 4'h0, 4'h0);
      add(4'h0,  5, 4'h1, 4'h0, 4'h0);   // 5-cycle low glitch
      add(4'h1, 12, 4'h1, 4'h0, 4'h0);   // level survives it
      add(4'h0, 10, 4'h1, 4'h0, 4'h0);   // long low
      add(4'h0,  1, 4'h0, 4'h0, 4'h1);
      add(4'h0,  9, 4'h0, 4'h0, 4'h0);
      add(4'hF, 10, 4'h0, 4'h0, 4'h0);   // all channels together
      add(4'hF,  1, 4'hF, 4'hF, 4'h0);
      add(4'hF,  1, 4'hF, 4'h0, 4'h0);
      add(4'h0, 10, 4'hF, 4'h0, 4'h0);
      add(4'h0,  1, 4'h0, 4'h0, 4'hF);
      add(4'h0,  3, 4'h0, 4'h0, 4'h0);

      for (int i = 0; i < 3; i++) step('0, 1'b1);
      check("reset_out", {16'h0, btn_level, btn_press, btn_release, btn_hold}, 32'h0);
      for (int i = 0; i < 4; i++) step('0, 1'b0);

      for (int t = 0; t < tbl.size(); t++) begin
         for (int i = 0; i < tbl[t].n; i++) step(tbl[t].btn, 1'b0);
         check($sformatf("tbl%0d", t), {20'h0, btn_level, btn_press, btn_release},
               {20'h0, tbl[t].lvl, tbl[t].prs, tbl[t].rel});
      end

      // Bounce: 1,0,1,0 every 3 cycles then hold on channel 1
      burst_then_hold("bounce", 1, 3, 3, 2);
      // A single low sample inside the window restarts qualification
      burst_then_hold("dip", 3, 6, 1, 1);

      // Reset while channel 0 is mid-qualification (cnt=5)
      for (int i = 0; i < 8; i++) step(4'h1, 1'b0);
      check("rst_mid_pre", {31'h0, btn_level[0]}, 32'h0);
      step(4'h1, 1'b1);
      check("rst_mid_out", {16'h0, btn_level, btn_press, btn_release, btn_hold}, 32'h0);
      press_at = -1;
      for (int i = 0; i < 30; i++) begin
         step(4'h1, 1'b0);
         if (btn_press[0] && press_at < 0) press_at = i;
      end
      check("rst_mid_press_lat", press_at, DB + 2);
      for (int i = 0; i < DB + 6; i++) step('0, 1'b0);

      // Long press on channel 2, held 64 cycles past the press
      p = -1; nh = 0; hat = -1;
      for (int i = 0; i < 75; i++) begin
         step(4'h4, 1'b0);
         if (btn_press[2] && p < 0) p = i;
         if (btn_hold[2]) begin
            nh++;
            if (hat < 0) hat = i;
         end
      end
      check("hold_press_lat", p, DB + 2);
`ifdef BUTTON_HOLD_EN
      check("hold_count", nh, 1);
      check("hold_latency", hat - p, HOLD);
`else
      check("hold_count", nh, 0);
`endif
      for (int i = 0; i < DB + 6; i++) step('0, 1'b0);

      // Randomised slow-toggling buttons with occasional reset, against the model
      begin
         logic [N_CH-1:0] b;
         b = '0;
         for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N_CH; c++)
               if ($urandom_range(0, 9) == 0) b[c] = !b[c];
            step(b, ($urandom_range(0, 599) == 0));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
